// File: rtl/mt_csr_file.sv
// mt_csr_file: multi-hart machine CSR file with per-hart trap state and a shared mtvec
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   csr_hart/op/addr/wr_data       CSR instruction (op 00 NOP, 01 WRITE, 10 SET, 11 CLEAR)
//   csr_rd_data                    combinational read of csr_hart/csr_addr
//   exp_hart, save_exp, exp_code,  exception capture / return for exp_hart
//   exp_pc, restore_exp
//   mepc_o                         mepc of exp_hart
//   mtvec_o                        shared trap vector
//   mstatus_ie_o                   per-hart interrupt enable
//   instret                        per-hart retire pulse
// Optional: define CSR_COUNTERS_EN to add mcycle (shared) and minstret (per hart).
module mt_csr_file #(
   parameter int          HART_NUM  = 4,
   parameter int          HART_ID_W = 2,
   parameter logic [31:0] MTVEC_RST = 32'h0000_0100
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [HART_ID_W-1:0] csr_hart,
   input  logic [1:0]           csr_op,
   input  logic [11:0]          csr_addr,
   input  logic [31:0]          csr_wr_data,
   output logic [31:0]          csr_rd_data,
   input  logic [HART_ID_W-1:0] exp_hart,
   input  logic                 save_exp,
   input  logic [5:0]           exp_code,
   input  logic [31:0]          exp_pc,
   input  logic                 restore_exp,
   output logic [31:0]          mepc_o,
   output logic [31:0]          mtvec_o,
   output logic [HART_NUM-1:0]  mstatus_ie_o,
   input  logic [HART_NUM-1:0]  instret
);
   logic [HART_NUM-1:0]  ie, eie, sv, rs, cw;
   logic [31:0]          mepc [HART_NUM];
   logic [5:0]           mcause [HART_NUM];
   logic [31:0]          mscratch [HART_NUM];
   logic [31:0]          mtvec, rd, wv;
   logic                 hart_ok, exp_ok, we;
   logic [HART_ID_W-1:0] hs, es;
`ifdef CSR_COUNTERS_EN
   logic [63:0]          mcycle;
   logic [63:0]          minstret [HART_NUM];
`else
   logic                 unused_instret;
   assign unused_instret = ^instret;
`endif
   // Out-of-range harts are clamped to 0 for indexing; hart_ok masks their effect.
   assign hart_ok      = int'(csr_hart) < HART_NUM;
   assign exp_ok       = int'(exp_hart) < HART_NUM;
   assign hs           = hart_ok ? csr_hart : '0;
   assign es           = exp_ok ? exp_hart : '0;
   assign we           = hart_ok && csr_op != 2'b00;
   assign csr_rd_data  = rd;
   assign mepc_o       = exp_ok ? mepc[es] : '0;
   assign mtvec_o      = mtvec;
   assign mstatus_ie_o = ie;
   always_comb begin
      rd = '0;
      if (hart_ok)
         case (csr_addr)
            12'h300: rd = {29'b0, 2'b11, ie[hs]};
            12'h7C0: rd = {29'b0, 2'b11, eie[hs]};
            12'h340: rd = mscratch[hs];
            12'h341: rd = mepc[hs];
            12'h342: rd = {mcause[hs][5], 26'b0, mcause[hs][4:0]};
            12'h305: rd = mtvec;
            12'hF00: rd = 32'h0000_0100;
            12'hF01: rd = 32'h0000_8000;
            12'hF14: rd = 32'(csr_hart);
`ifdef CSR_COUNTERS_EN
            12'hB00: rd = mcycle[31:0];
            12'hB80: rd = mcycle[63:32];
            12'hB02: rd = minstret[hs][31:0];
            12'hB82: rd = minstret[hs][63:32];
`endif
            default: rd = '0;
         endcase
   end
   // Write value for WRITE/SET/CLEAR; only used when we is asserted.
   assign wv = (csr_op == 2'b01) ? csr_wr_data :
               (csr_op == 2'b10) ? (csr_wr_data | rd) : (~csr_wr_data & rd);
   // Save beats restore; restore only fires alone.
   always_comb begin
      sv = '0;
      rs = '0;
      cw = '0;
      for (int h = 0; h < HART_NUM; h++) begin
         sv[h] = save_exp && int'(exp_hart) == h;
         rs[h] = restore_exp && !save_exp && int'(exp_hart) == h;
         cw[h] = we && int'(csr_hart) == h;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         ie    <= '0;
         eie   <= '0;
         mtvec <= MTVEC_RST;
         for (int h = 0; h < HART_NUM; h++) begin
            mepc[h]     <= '0;
            mcause[h]   <= '0;
            mscratch[h] <= '0;
`ifdef CSR_COUNTERS_EN
            minstret[h] <= '0;
`endif
         end
`ifdef CSR_COUNTERS_EN
         mcycle <= '0;
`endif
      end else begin
         if (we && csr_addr == 12'h305) mtvec <= wv & ~32'h3;
         for (int h = 0; h < HART_NUM; h++) begin
            // Exception capture owns ie/eie/mepc/mcause of its hart this edge.
            if (sv[h]) begin
               ie[h]     <= 1'b0;
               eie[h]    <= ie[h];
               mepc[h]   <= exp_pc & ~32'h3;
               mcause[h] <= exp_code;
            end else begin
               if (rs[h]) ie[h] <= eie[h];
               else if (cw[h] && csr_addr == 12'h300) ie[h] <= wv[0];
               if (cw[h] && csr_addr == 12'h7C0) eie[h] <= wv[0];
               if (cw[h] && csr_addr == 12'h341) mepc[h] <= wv & ~32'h3;
               if (cw[h] && csr_addr == 12'h342) mcause[h] <= {wv[31], wv[4:0]};
            end
            if (cw[h] && csr_addr == 12'h340) mscratch[h] <= wv;
`ifdef CSR_COUNTERS_EN
            minstret[h] <= (cw[h] && csr_addr == 12'hB02) ? {minstret[h][63:32], wv} :
                           (cw[h] && csr_addr == 12'hB82) ? {wv, minstret[h][31:0]} :
                           minstret[h] + 64'(instret[h]);
`endif
         end
`ifdef CSR_COUNTERS_EN
         mcycle <= (we && csr_addr == 12'hB00) ? {mcycle[63:32], wv} :
                   (we && csr_addr == 12'hB80) ? {wv, mcycle[31:0]} : mcycle + 64'd1;
`endif
      end
   end
endmodule

// File: tb/tb_mt_csr_file.sv
// tb_mt_csr_file: directed self-checking bench for mt_csr_file
module tb_mt_csr_file;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  csr_hart = '0;
   logic [1:0]  csr_op = '0;
   logic [11:0] csr_addr = '0;
   logic [31:0] csr_wr_data = '0;
   logic [31:0] csr_rd_data;
   logic [2:0]  exp_hart = '0;
   logic        save_exp = 1'b0;
   logic [5:0]  exp_code = '0;
   logic [31:0] exp_pc = '0;
   logic        restore_exp = 1'b0;
   logic [31:0] mepc_o, mtvec_o;
   logic [3:0]  mstatus_ie_o;
   logic [3:0]  instret = '0;
   int          checks = 0;
   int          failures = 0;
   mt_csr_file #(.HART_NUM(4), .HART_ID_W(3), .MTVEC_RST(32'h0000_0100)) dut (
      .clk(clk), .reset(reset), .csr_hart(csr_hart), .csr_op(csr_op), .csr_addr(csr_addr),
      .csr_wr_data(csr_wr_data), .csr_rd_data(csr_rd_data), .exp_hart(exp_hart),
      .save_exp(save_exp), .exp_code(exp_code), .exp_pc(exp_pc), .restore_exp(restore_exp),
      .mepc_o(mepc_o), .mtvec_o(mtvec_o), .mstatus_ie_o(mstatus_ie_o), .instret(instret)
   );
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic rd(input string tag, input logic [2:0] h, input logic [11:0] a, input logic [31:0] exp);
      csr_hart = h;
      csr_addr = a;
      #1;
      chk(tag, csr_rd_data, exp);
   endtask
   task automatic wr(input logic [2:0] h, input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
      csr_hart    = h;
      csr_addr    = a;
      csr_op      = op;
      csr_wr_data = d;
      tick;
      csr_op      = 2'b00;
      save_exp    = 1'b0;
      restore_exp = 1'b0;
   endtask
   initial begin
      save_exp = 1'b1; exp_pc = 32'h4444; exp_code = 6'h3F; restore_exp = 1'b1; instret = 4'hF;
      csr_hart = 3'd0; csr_addr = 12'h340; csr_op = 2'b01; csr_wr_data = 32'hAA;
      tick;
      tick;
      reset = 1'b0; save_exp = 1'b0; restore_exp = 1'b0; instret = '0; csr_op = 2'b00;
      tick;
      chk("rst_ie_o", 32'(mstatus_ie_o), 32'h0);
      chk("rst_mepc_o", mepc_o, 32'h0);
      chk("rst_mtvec_o", mtvec_o, 32'h100);
      rd("rst_mtvec", 3'd0, 12'h305, 32'h100);
      rd("rst_ms_h0", 3'd0, 12'h300, 32'h6);
      rd("rst_ms_h3", 3'd3, 12'h300, 32'h6);
      rd("rst_scratch", 3'd0, 12'h340, 32'h0);
      rd("rst_mcause", 3'd0, 12'h342, 32'h0);
      wr(3'd2, 12'h300, 2'b01, 32'h1);
      rd("ie_wr_h2", 3'd2, 12'h300, 32'h7);
      chk("ie_o_h2", 32'(mstatus_ie_o), 32'h4);
      exp_hart = 3'd2; exp_code = 6'h25; exp_pc = 32'h1003; save_exp = 1'b1;
      tick;
      save_exp = 1'b0;
      rd("sv_ms", 3'd2, 12'h300, 32'h6);
      rd("sv_mes", 3'd2, 12'h7C0, 32'h7);
      rd("sv_mepc", 3'd2, 12'h341, 32'h1000);
      rd("sv_mcause", 3'd2, 12'h342, 32'h8000_0005);
      chk("sv_mepc_o", mepc_o, 32'h1000);
      rd("sv_h1_ms", 3'd1, 12'h300, 32'h6);
      rd("sv_h1_mepc", 3'd1, 12'h341, 32'h0);
      wr(3'd1, 12'h300, 2'b01, 32'h1);
      exp_hart = 3'd1; exp_code = 6'h01; exp_pc = 32'h2220; save_exp = 1'b1; restore_exp = 1'b1;
      tick;
      save_exp = 1'b0; restore_exp = 1'b0;
      rd("both_ms", 3'd1, 12'h300, 32'h6);
      rd("both_mes", 3'd1, 12'h7C0, 32'h7);
      restore_exp = 1'b1;
      tick;
      restore_exp = 1'b0;
      rd("rest_ms", 3'd1, 12'h300, 32'h7);
      chk("rest_ie_o", 32'(mstatus_ie_o), 32'h2);
      exp_hart = 3'd3; exp_code = 6'h02; exp_pc = 32'h2000; save_exp = 1'b1;
      wr(3'd3, 12'h341, 2'b01, 32'hDEAD_0000);
      rd("prio_mepc", 3'd3, 12'h341, 32'h2000);
      exp_pc = 32'h3001; save_exp = 1'b1;
      wr(3'd0, 12'h340, 2'b01, 32'h55);
      rd("par_scratch", 3'd0, 12'h340, 32'h55);
      rd("par_mepc", 3'd3, 12'h341, 32'h3000);
      chk("par_mepc_o", mepc_o, 32'h3000);
      wr(3'd3, 12'h340, 2'b01, 32'h0F);
      wr(3'd3, 12'h340, 2'b10, 32'hF0);
      rd("set", 3'd3, 12'h340, 32'hFF);
      wr(3'd3, 12'h340, 2'b11, 32'h0F);
      rd("clear", 3'd3, 12'h340, 32'hF0);
      wr(3'd4, 12'h340, 2'b01, 32'h77);
      rd("oor_rd", 3'd4, 12'h340, 32'h0);
      rd("oor_h0", 3'd0, 12'h340, 32'h55);
      rd("oor_h1", 3'd1, 12'h340, 32'h0);
      rd("oor_h3", 3'd3, 12'h340, 32'hF0);
      rd("hartid3", 3'd3, 12'hF14, 32'h3);
      rd("hartid_oor", 3'd4, 12'hF14, 32'h0);
      rd("f01", 3'd0, 12'hF01, 32'h8000);
      wr(3'd0, 12'hF00, 2'b01, 32'h0);
      rd("ro_f00", 3'd0, 12'hF00, 32'h100);
      rd("unmapped", 3'd0, 12'h123, 32'h0);
      wr(3'd1, 12'h305, 2'b01, 32'h1237);
      rd("mtvec_wr", 3'd0, 12'h305, 32'h1234);
      chk("mtvec_o_wr", mtvec_o, 32'h1234);
      wr(3'd0, 12'h341, 2'b01, 32'hFFFF_FFFF);
      rd("mepc_align", 3'd0, 12'h341, 32'hFFFF_FFFC);
      wr(3'd0, 12'h342, 2'b10, 32'hFFFF_FFFF);
      rd("mcause_set", 3'd0, 12'h342, 32'h8000_001F);
`ifdef CSR_COUNTERS_EN
      wr(3'd0, 12'hB80, 2'b01, 32'h0);
      wr(3'd0, 12'hB00, 2'b01, 32'hFFFF_FFFF);
      rd("cyc_lo_wr", 3'd0, 12'hB00, 32'hFFFF_FFFF);
      rd("cyc_hi_wr", 3'd0, 12'hB80, 32'h0);
      tick;
      rd("cyc_lo_wrap", 3'd0, 12'hB00, 32'h0);
      rd("cyc_hi_carry", 3'd0, 12'hB80, 32'h1);
      instret = 4'b0001;
      repeat (3) tick;
      instret = '0;
      rd("instret_h0", 3'd0, 12'hB02, 32'h3);
      rd("instret_h1", 3'd1, 12'hB02, 32'h0);
`else
      repeat (100) tick;
      rd("nocnt_idle", 3'd0, 12'hB00, 32'h0);
      wr(3'd0, 12'hB00, 2'b01, 32'h1234);
      rd("nocnt_wr", 3'd0, 12'hB00, 32'h0);
      rd("nocnt_hi", 3'd0, 12'hB80, 32'h0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mt_csr_file.md
MT_CSR_FILE -- requirements
Module: mt_csr_file

Interface
REQ-001 SHALL provide parameter HART_NUM, default 4, number of hardware threads with private CSR state.
REQ-002 SHALL provide parameter HART_ID_W, default 2, width of hart index ports (ceil(log2(HART_NUM)), minimum 1).
REQ-003 SHALL provide parameter MTVEC_RST, default 32'h0000_0100, reset value of mtvec.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 csr_hart  in  HART_ID_W  hart addressed by the CSR instruction.
REQ-007 csr_op  in  2  00 NOP, 01 WRITE, 10 SET, 11 CLEAR.
REQ-008 csr_addr  in  12  CSR address.
REQ-009 csr_wr_data  in  32  operand for WRITE/SET/CLEAR.
REQ-010 csr_rd_data  out  32  combinational read data for csr_hart/csr_addr.
REQ-011 exp_hart  in  HART_ID_W  hart targeted by save_exp/restore_exp; also selects mepc_o.
REQ-012 save_exp  in  1  capture exception for exp_hart.
REQ-013 exp_code  in  6  cause; bit5 interrupt flag, bits4:0 code.
REQ-014 exp_pc  in  32  faulting PC.
REQ-015 restore_exp  in  1  return from exception for exp_hart.
REQ-016 mepc_o  out  32  mepc of exp_hart, combinational.
REQ-017 mtvec_o  out  32  shared trap vector.
REQ-018 mstatus_ie_o  out  HART_NUM  per-hart interrupt enable, bit h = hart h.
REQ-019 instret  in  HART_NUM  per-hart retire pulse, bit h = hart h.

Function
REQ-020 Per hart SHALL hold mstatus.IE, mestatus.IE, mepc[31:0], mcause[5:0], mscratch[31:0]; mtvec SHALL be shared.
REQ-021 Read map: 0x300 {29'b0,2'b11,IE}; 0x7C0 {29'b0,2'b11,eIE}; 0x340 mscratch; 0x341 mepc; 0x342 {mcause[5],26'b0,mcause[4:0]}; 0x305 mtvec; 0xF00 32'h0000_0100; 0xF01 32'h0000_8000; 0xF14 csr_hart zero-extended; any other address 32'h0.
REQ-022 SET result SHALL be csr_wr_data | read value; CLEAR result (~csr_wr_data) & read value; NOP SHALL write nothing.
REQ-023 Writes SHALL commit at the next rising edge; read of same CSR SHALL show new value the following cycle.
REQ-024 Read-only addresses (0xF00, 0xF01, 0xF14) and unmapped addresses SHALL ignore writes.
REQ-025 mepc[1:0] and mtvec[1:0] SHALL always be 0 regardless of written data or exp_pc.
REQ-026 csr_hart >= HART_NUM SHALL read 32'h0 and suppress writes.
REQ-027 save_exp SHALL in one edge set mepc=exp_pc, mcause=exp_code, eIE=IE (pre-edge), IE=0 for exp_hart.
REQ-028 restore_exp SHALL in one edge set IE=eIE for exp_hart.
REQ-029 save_exp and restore_exp together SHALL perform save only.
REQ-030 save/restore SHALL take priority over a CSR write to the same register of the same hart; different harts/registers SHALL both update that edge.
REQ-031 Only the addressed hart's state SHALL change on a CSR write.

Reset
REQ-032 On reset: all IE and eIE 0, mepc 0, mcause 0, mscratch 0, mtvec MTVEC_RST, counters 0; mstatus_ie_o all-zero next cycle.
REQ-033 reset SHALL override save_exp, restore_exp, csr_op and instret asserted in the same cycle.

Configuration
REQ-034 Macro CSR_COUNTERS_EN defined: shared 64-bit mcycle incrementing every non-reset cycle, per-hart 64-bit minstret incrementing when instret[h]=1; read 0xB00/0xB80 mcycle low/high, 0xB02/0xB82 minstret low/high of csr_hart; writable, CSR write SHALL replace that half and suppress the increment that cycle; carry SHALL propagate low->high; all-ones SHALL wrap to 0.
REQ-035 Macro undefined: no counter flops; those addresses SHALL read 32'h0, ignore writes; instret ignored.

Verification
REQ-036 Reset, then read 0x305 hart0 -> 32'h0000_0100; 0x300 any hart -> 32'h0000_0006.
REQ-037 WRITE 0x300=1 hart2, then save_exp hart2 exp_code=6'h25 exp_pc=32'h1003 -> 0x300=6, 0x7C0=7, 0x341=32'h1000, 0x342=32'h8000_0005; hart1 unchanged.
REQ-038 Same cycle save_exp+restore_exp hart1 (IE=1) -> IE=0, eIE=1; next cycle restore alone -> IE=1.
REQ-039 SET 0x340 hart3 with 32'hF0 over 32'h0F -> 32'hFF; CLEAR 32'h0F -> 32'hF0; csr_hart=HART_NUM write -> no hart changes, read 0.
REQ-040 With CSR_COUNTERS_EN: WRITE 0xB00=32'hFFFF_FFFF, next cycle mcycle high increments by 1, low reads 0; instret[0] pulsed 3 cycles -> 0xB02 hart0 = 3, hart1 = 0.
REQ-041 Without CSR_COUNTERS_EN: 0xB00 reads 0 after 100 cycles and after a WRITE of 32'h1234.
